fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    RUN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular queue with synchronous flush and an occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: issues word requests, tags in-order responses
// with their PC, buffers them for decode and discards stale data after a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int              CW   = $clog2(FQ_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   redirect_target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       inflight;
  logic              accept;
  logic              resp_live;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] head;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign accept          = imem_req && imem_gnt;
  assign resp_live       = imem_rvalid && (outstanding != '0);
  assign push            = resp_live && (drop_cnt == '0) && !redirect_valid && !fifo_full;
  assign pop             = !fifo_empty && if_ready && !redirect_valid;
  assign inflight        = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_addr       = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Every request in flight already owns a queue slot, so the queue cannot overflow.
  always_comb begin
    imem_req = 1'b0;
    if (state == RUN && inflight < (CW+1)'(FQ_DEPTH)) begin
      imem_req = 1'b1;
    end
  end

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !resp_live) begin
      outstanding_next = outstanding + CW'(1);
    end else if (!accept && resp_live) begin
      outstanding_next = outstanding - CW'(1);
    end
  end

  // On redirect everything still in flight, including a same-cycle grant, is stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        drop_cnt <= outstanding_next;
      end else if (resp_live && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // resp_pc shadows the address of the oldest live response, so no tag FIFO is needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc      <= redirect_target;
      resp_pc <= redirect_target;
    end else begin
      if (accept) begin
        pc <= pc + STEP;
      end
      if (push) begin
        resp_pc <= resp_pc + STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (2*XLEN)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign if_valid = !fifo_empty;
  assign if_pc    = fifo_empty ? '0 : head[2*XLEN-1:XLEN];
  assign if_instr = fifo_empty ? '0 : head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus an instruction-stream model
// that expects sequential PCs from the last redirect target.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic        gnt;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           cyc = 0;
  int           lat = 1;
  int           grants = 0;
  int           pops = 0;
  logic         stale_en = 1'b0;
  logic [31:0]  exp_pc;
  logic [31:0]  exp_fetch;
  mem_req_t     mem_q[$];
  fetch_entry_t pop_log[$];
  vec_t         vecs[10];

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // One clock: drive inputs, run the stream model, step the memory model.
  task automatic apply_stimulus(input logic gnt, input logic ready, input logic redir,
                                input logic [31:0] rpc);
    mem_req_t     r;
    fetch_entry_t e;
    logic         accepted;
    logic         stall_now;
    logic [31:0]  acc_addr;
    imem_gnt       = gnt;
    if_ready       = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
      r           = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(r.addr);
    end else if (mem_q.size() == 0 && stale_en && $urandom_range(0, 7) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    accepted = imem_req && gnt;
    acc_addr = imem_addr;
    if (accepted) begin
      check_output("fetch_addr", imem_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      grants++;
    end
    if (redir) begin
      exp_fetch = rpc & 32'hFFFF_FFFC;
      exp_pc    = rpc & 32'hFFFF_FFFC;
    end else if (if_valid && ready) begin
      check_output("stream_pc", if_pc, exp_pc);
      check_output("stream_instr", if_instr, instr_of(exp_pc));
      e.pc    = if_pc;
      e.instr = if_instr;
      pop_log.push_back(e);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    stall_now = imem_req && !gnt && !redir;
    @(posedge clk);
    cyc++;
    if (accepted) begin
      r.addr = acc_addr;
      r.due  = cyc + lat;
      mem_q.push_back(r);
    end
    @(negedge clk);
    if (stall_now) begin
      check_output("stall_req", imem_req, 1);
      check_output("stall_addr", imem_addr, acc_addr);
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    mem_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_req", imem_req, 0);
    check_output("rst_addr", imem_addr, 32'h0);
    check_output("rst_valid", if_valid, 0);
    check_output("rst_if_pc", if_pc, 0);
    check_output("rst_if_instr", if_instr, 0);
    reset_n = 1'b1;
    #1;
    check_output("idle_req", imem_req, 0);
    exp_pc    = 32'h0;
    exp_fetch = 32'h0;
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (!if_valid && n < max) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check_output("wait_valid", if_valid, 1);
  endtask

  initial begin
    reset_n = 1'b0;

    // Rows are indexed by the clock edge after reset release, latency 1.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h00};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

    $display("[TB] table: sequential fetch after reset");
    lat = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].gnt, vecs[i].ready, 1'b0, 32'h0);
      check_output($sformatf("v%0d_req", i), imem_req, vecs[i].exp_req);
      check_output($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check_output($sformatf("v%0d_valid", i), if_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check_output($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
        check_output($sformatf("v%0d_instr", i), if_instr, instr_of(vecs[i].exp_pc));
      end
    end

    $display("[TB] backpressure fills queue");
    lat = 1;
    do_reset();
    grants = 0;
    repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("bp_grants", grants, 4);
    check_output("bp_req_off", imem_req, 0);
    check_output("bp_head_pc", if_pc, 32'h0);
    grants = 0;
    pop_log.delete();
    repeat (10) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size()) begin
        check_output($sformatf("bp_pop%0d", i), pop_log[i].pc, 32'(i * 4));
      end else begin
        check_output($sformatf("bp_pop%0d_missing", i), 0, 1);
      end
    end
    check_output("bp_resume", grants > 0, 1);

    $display("[TB] grant stall holds address");
    lat = 1;
    do_reset();
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("stall_start", imem_addr, 32'h8);
    repeat (3) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("stall_hold", imem_addr, 32'h8);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("stall_release", imem_addr, 32'hC);

    $display("[TB] redirect with two outstanding");
    lat = 3;
    do_reset();
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h103);
    check_output("redir_addr", imem_addr, 32'h100);
    check_output("redir_flush", if_valid, 0);
    repeat (3) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("redir_drop", if_valid, 0);
    end
    wait_valid(12);
    check_output("redir_first_pc", if_pc, 32'h100);
    check_output("redir_first_instr", if_instr, 32'h113);
    repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);

    $display("[TB] address wrap");
    lat = 1;
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check_output("wrap_top", imem_addr, 32'hFFFF_FFFC);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("wrap_zero", imem_addr, 32'h0);
    repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);

    $display("[TB] reset mid-burst");
    lat = 2;
    do_reset();
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("mid_pre_valid", if_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check_output("mid_req", imem_req, 0);
    check_output("mid_valid", if_valid, 0);
    check_output("mid_addr", imem_addr, 32'h0);
    check_output("mid_if_pc", if_pc, 0);
    check_output("mid_if_instr", if_instr, 0);
    mem_q.delete();
    imem_gnt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    exp_pc    = 32'h0;
    exp_fetch = 32'h0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    repeat (2) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    check_output("mid_stale_ignored", if_valid, 0);
    lat = 1;
    wait_valid(10);
    check_output("mid_first_pc", if_pc, 32'h0);
    check_output("mid_first_instr", if_instr, 32'h13);

    $display("[TB] randomized traffic");
    do_reset();
    stale_en = 1'b1;
    pops = 0;
    for (int i = 0; i < 1500; i++) begin
      logic        g;
      logic        rdy;
      logic        rd;
      logic [31:0] tgt;
      lat = $urandom_range(1, 4);
      g   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 31) == 0);
      tgt = $urandom;
      apply_stimulus(g, rdy, rd, tgt);
    end
    stale_en = 1'b0;
    check_output("rand_progress", pops >= 100, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
